// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with arbitrary depth, registered or fall-through
// read, threshold flags, occupancy count and sticky error flags.
module ring_fifo #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_LEVEL  = DEPTH - 2,
   parameter int AEMPTY_LEVEL = 2,
   parameter int FWFT         = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clear_flags
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (count >= CW'(AFULL_LEVEL));
   assign almost_empty = (count <= CW'(AEMPTY_LEVEL));

   // A pop frees the slot, so a full FIFO still takes a paired push.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (!push_ok && pop_ok)
            count <= count - 1'b1;
         overflow  <= (overflow && !clear_flags)
                      || (push && !push_ok);
         underflow <= (underflow && !clear_flags)
                      || (pop && !pop_ok);
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok && !reset)
         mem[wr_ptr] <= push_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign pop_data = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [WIDTH-1:0] data_q;
         always_ff @(posedge clock) begin
            if (reset)
               data_q <= '0;
            else if (pop_ok)
               data_q <= mem[rd_ptr];
         end
         assign pop_data = data_q;
      end
   endgenerate

endmodule

// File: tb/tb_ring_fifo.sv
// Bench for ring_fifo: registered-read and fall-through instances driven
// together, checked each cycle against queue models plus directed literals.
module tb_ring_fifo;

   localparam int D0  = 5;
   localparam int AF0 = 3;
   localparam int AE0 = 2;
   localparam int D1  = 4;
   localparam int AF1 = 2;
   localparam int AE1 = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic       clear_flags;

   logic [7:0] pop_data0, pop_data1;
   logic [2:0] count0, count1;
   logic       full0, empty0, af0, ae0, ov0, un0;
   logic       full1, empty1, af1, ae1, ov1, un1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   ring_fifo #(.WIDTH(8), .DEPTH(D0), .FWFT(0)) u0 (
      .clock(clock), .reset(reset), .push(push),
      .push_data(push_data), .pop(pop), .pop_data(pop_data0),
      .count(count0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0),
      .overflow(ov0), .underflow(un0), .clear_flags(clear_flags)
   );

   ring_fifo #(.WIDTH(8), .DEPTH(D1), .FWFT(1)) u1 (
      .clock(clock), .reset(reset), .push(push),
      .push_data(push_data), .pop(pop), .pop_data(pop_data1),
      .count(count1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1),
      .overflow(ov1), .underflow(un1), .clear_flags(clear_flags)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] md0;
   bit mov0, mun0, mov1, mun1;
   bit po, pu;
   bit started = 0;

   always @(posedge clock) begin
      if (reset) begin
         q0.delete();
         q1.delete();
         md0 = '0;
         mov0 = 0; mun0 = 0; mov1 = 0; mun1 = 0;
         started = 1;
      end else if (started) begin
         po = pop && (q0.size() > 0);
         pu = push && ((q0.size() < D0) || po);
         mov0 = (mov0 && !clear_flags) || (push && !pu);
         mun0 = (mun0 && !clear_flags) || (pop && !po);
         if (po) md0 = q0.pop_front();
         if (pu) q0.push_back(push_data);
         po = pop && (q1.size() > 0);
         pu = push && ((q1.size() < D1) || po);
         mov1 = (mov1 && !clear_flags) || (push && !pu);
         mun1 = (mun1 && !clear_flags) || (pop && !po);
         if (po) void'(q1.pop_front());
         if (pu) q1.push_back(push_data);
      end
      #1;
      if (started) begin
         chk("count0", count0, q0.size());
         chk("full0", full0, q0.size() == D0);
         chk("empty0", empty0, q0.size() == 0);
         chk("afull0", af0, q0.size() >= AF0);
         chk("aempty0", ae0, q0.size() <= AE0);
         chk("ovf0", ov0, mov0);
         chk("unf0", un0, mun0);
         chk("data0", pop_data0, md0);
         chk("count1", count1, q1.size());
         chk("full1", full1, q1.size() == D1);
         chk("empty1", empty1, q1.size() == 0);
         chk("afull1", af1, q1.size() >= AF1);
         chk("aempty1", ae1, q1.size() <= AE1);
         chk("ovf1", ov1, mov1);
         chk("unf1", un1, mun1);
         chk("data1", pop_data1, q1.size() > 0 ? q1[0] : 8'h00);
      end
   end

   task automatic step(input bit p, input logic [7:0] d,
                       input bit q, input bit c);
      push = p;
      push_data = d;
      pop = q;
      clear_flags = c;
      @(negedge clock);
      push = 0;
      pop = 0;
      clear_flags = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      step(0, 8'h00, 0, 0);
      reset = 0;
   endtask

   int bias;

   initial begin
      reset = 1; push = 0; pop = 0;
      push_data = 0; clear_flags = 0;
      @(negedge clock);
      do_reset();
      chk("rst_count", count0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_aempty", ae0, 1);
      chk("rst_full", full0, 0);

      for (int i = 1; i <= 5; i++) step(1, 8'(i * 8'h11), 0, 0);
      chk("t1_count", count0, 5);
      chk("t1_full", full0, 1);
      chk("t1_afull", af0, 1);
      for (int i = 1; i <= 5; i++) begin
         step(0, 8'h00, 1, 0);
         chk("t1_data", pop_data0, i * 8'h11);
      end
      chk("t1_empty", empty0, 1);
      chk("t1_count0", count0, 0);

      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 3; i++) step(1, 8'(3 * r + i), 0, 0);
         for (int i = 1; i <= 3; i++) begin
            step(0, 8'h00, 1, 0);
            chk("t2_data", pop_data0, 3 * r + i);
         end
         chk("t2_count", count0, 0);
      end

      do_reset();
      for (int i = 1; i <= 5; i++) step(1, 8'(8'h60 + i), 0, 0);
      step(1, 8'hAA, 1, 0);
      chk("t3_count", count0, 5);
      chk("t3_ovf", ov0, 0);
      chk("t3_first", pop_data0, 8'h61);
      step(1, 8'hBB, 0, 0);
      chk("t3_ovf_set", ov0, 1);
      for (int i = 2; i <= 5; i++) begin
         step(0, 8'h00, 1, 0);
         chk("t3_data", pop_data0, 8'h60 + i);
      end
      step(0, 8'h00, 1, 0);
      chk("t3_aa", pop_data0, 8'hAA);
      chk("t3_empty", empty0, 1);

      do_reset();
      step(1, 8'h5A, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      chk("t4_unf", un0, 1);
      chk("t4_hold", pop_data0, 8'h5A);
      step(1, 8'h3C, 1, 0);
      chk("t4_count", count0, 1);
      chk("t4_unf_hold", un0, 1);
      step(0, 8'h00, 0, 1);
      chk("t4_clear", un0, 0);

      do_reset();
      step(1, 8'h7E, 0, 0);
      chk("t5_fwft", pop_data1, 8'h7E);
      step(0, 8'h00, 1, 0);
      chk("t5_zero", pop_data1, 8'h00);
      chk("t5_empty", empty1, 1);

      for (int i = 1; i <= 3; i++) step(1, 8'(i), 0, 0);
      reset = 1;
      step(1, 8'h99, 0, 0);
      reset = 0;
      chk("t6_count", count0, 0);
      chk("t6_empty", empty0, 1);
      chk("t6_data", pop_data0, 8'h00);
      chk("t6_ovf", ov0, 0);
      step(0, 8'h00, 1, 0);
      chk("t6_unf", un0, 1);
      chk("t6_no99", pop_data0, 8'h00);

      for (int n = 0; n < 3000; n++) begin
         case ((n / 150) % 3)
            0: bias = 70;
            1: bias = 30;
            default: bias = 50;
         endcase
         reset = ($urandom_range(0, 249) == 0);
         step($urandom_range(0, 99) < bias, 8'($urandom),
              $urandom_range(0, 99) < (100 - bias),
              $urandom_range(0, 15) == 0);
         reset = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
Parametrised circular-buffer FIFO. It replaces the shift-register queue in buff_uart, with pointer-based storage, non-power-of-two depth, a selectable read mode, almost-full/empty thresholds, an occupancy count and sticky error flags. It sits between the UART byte engines and their producers/consumers, on a single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer, not restricted to powers of two)
AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)
AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous reset, active-high
push  in  1  write request
push_data  in  WIDTH  write word
pop  in  1  read request
pop_data  out  WIDTH  read word
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_LEVEL
almost_empty  out  1  count <= AEMPTY_LEVEL
overflow  out  1  sticky: push rejected
underflow  out  1  sticky: pop rejected
clear_flags  in  1  clears overflow/underflow

Behaviour:
- One clock domain. Reset is synchronous and active-high, on ports clock/reset.
- Reset (reset=1 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, pop_data=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=0 (when AFULL_LEVEL>=1). Storage contents are not cleared.
- Reset dominates push/pop/clear_flags in the same cycle. Reset mid-operation discards all queued data.
- Storage: DEPTH x WIDTH array, wr_ptr and rd_ptr in 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not bit overflow.
- Flags are combinational decodes of the count register only. They never depend on push/pop in the current cycle.
- Accept rules (evaluated on the state before the edge):
  - push_ok = push && (!full || pop_ok).
  - pop_ok = pop && !empty.
- Push when full with no accepted pop: write dropped, overflow set.
- Pop when empty: read dropped, underflow set, pop_data unchanged.
- Simultaneous push+pop when empty: push accepted, pop rejected (underflow set), count 0->1.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, pointers both advance.
- Simultaneous push+pop otherwise: both accepted, count unchanged.
- On push_ok: mem[wr_ptr] <= push_data, wr_ptr advances.
- On pop_ok: rd_ptr advances.
- Count: +1 on push_ok only, -1 on pop_ok only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- FWFT=0 mode:
  - On pop_ok, pop_data <= mem[rd_ptr], registered. Read latency is 1 cycle after the accepted pop edge.
  - pop_data holds its last value otherwise (it is not zeroed).
- FWFT=1 mode:
  - pop_data = mem[rd_ptr] whenever !empty, and 0 when empty.
  - pop consumes the displayed word.
  - A word pushed into an empty FIFO appears on pop_data the cycle after the push edge.
- Sticky flags:
  - overflow/underflow set on the edge of the rejecting cycle and hold until cleared.
  - clear_flags=1 clears them at the edge.
  - If a new rejection occurs in the same cycle as clear_flags, set wins.
- Ordering: strict FIFO. No word is duplicated or lost except by rejected pushes or reset.

Test Plan:
1. WIDTH=8, DEPTH=5, FWFT=0: push 0x11..0x55 on 5 consecutive cycles -> count=5, full=1, almost_full=1. Then pop 5 cycles -> pop_data 0x11,0x22,0x33,0x44,0x55 each one cycle after its pop, ending with empty=1, count=0.
2. Wrap-around, DEPTH=5: run 3 rounds of push-3/pop-3 with values 0x01..0x09 -> output order matches exactly, pointers wrap past 4, count returns to 0 after each round.
3. Full with simultaneous push 0xAA + pop -> count stays 5, overflow=0, 0xAA emerges after the four remaining words. Then push 0xBB alone while full -> overflow=1, 0xBB never appears.
4. Empty: pop alone -> underflow=1, pop_data unchanged. Then push 0x3C + pop together -> count=1, underflow remains 1. Then clear_flags -> underflow=0 next cycle.
5. FWFT=1, DEPTH=4: push 0x7E into empty -> pop_data=0x7E the next cycle, with pop not yet asserted. Pop -> pop_data=0 and empty=1 after the edge.
6. Push 3 words, assert reset together with push 0x99 -> count=0, empty=1, pop_data=0, flags cleared. A subsequent pop gives underflow=1 and never outputs 0x99.
